// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven clear/enable/match sequencer
// for a single counter instance, one-shot or periodic.
module counter_sequencer #(
    parameter int PERIODS_WIDTH = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [7:0]               cmd_target_i,
    input  logic                     cmd_periodic_i,
    input  logic                     pause_i,
    input  logic                     abort_i,
    output logic                     cnt_reset_o,
    output logic                     cnt_enable_o,
    input  logic [7:0]               cnt_count_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [PERIODS_WIDTH-1:0] periods_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam logic [PERIODS_WIDTH-1:0] PMAX = '1;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] target_q;
    logic       periodic_q;
    logic       accept;
    logic       match;
    logic       done_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            periodic_q <= 1'b0;
            done_o     <= 1'b0;
            periods_o  <= '0;
        end else begin
            state_q <= state_d;
            done_o  <= done_d;
            if (accept) begin
                target_q   <= cmd_target_i;
                // a zero target can never restart usefully
                periodic_q <= cmd_periodic_i && (cmd_target_i != 8'd0);
                periods_o  <= '0;
            end else if (done_d && periods_o != PMAX) begin
                periods_o <= periods_o + PERIODS_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_ready_o  = 1'b0;
        cnt_enable_o = 1'b0;
        cnt_reset_o  = reset_i;
        busy_o       = !reset_i && (state_q != ST_IDLE);
        accept       = 1'b0;
        match        = 1'b0;
        done_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_o = !reset_i;
                accept      = cmd_valid_i && !reset_i;
                if (accept) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_reset_o = 1'b1;
                state_d     = abort_i ? ST_FLUSH : ST_RUN;
            end
            ST_RUN: begin
                // enable drops in the match cycle so the counter never overshoots
                match        = (cnt_count_i == target_q);
                cnt_enable_o = !reset_i && !pause_i && !match;
                if (abort_i) begin
                    state_d = ST_FLUSH;
                end else if (match) begin
                    done_d  = 1'b1;
                    state_d = periodic_q ? ST_CLEAR : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                cnt_reset_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed plan plus random traffic against
// a tick-budget reference model and a behavioural counter.
module tb_counter_sequencer;

    localparam int PW = 2;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [7:0]    cmd_target_i = '0;
    logic          cmd_periodic_i = 1'b0;
    logic          pause_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          cnt_reset_o;
    logic          cnt_enable_o;
    logic [7:0]    cnt_count_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [PW-1:0] periods_o;

    always #5 clock_i = ~clock_i;

    counter_sequencer #(.PERIODS_WIDTH(PW)) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_target_i(cmd_target_i),
        .cmd_periodic_i(cmd_periodic_i),
        .pause_i(pause_i),
        .abort_i(abort_i),
        .cnt_reset_o(cnt_reset_o),
        .cnt_enable_o(cnt_enable_o),
        .cnt_count_i(cnt_count_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .periods_o(periods_o)
    );

    // behavioural counter: one count per cpc enabled cycles
    int cpc = 1;
    int pre = 0;
    always @(posedge clock_i) begin
        if (cnt_reset_o) begin
            cnt_count_i <= '0;
            pre         <= 0;
        end else if (cnt_enable_o) begin
            if (pre >= cpc - 1) begin
                pre         <= 0;
                cnt_count_i <= cnt_count_i + 8'd1;
            end else begin
                pre <= pre + 1;
            end
        end
    end

    typedef enum {P_IDLE, P_CLEAR, P_RUN, P_FLUSH} phase_e;

    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    phase_e ph = P_IDLE;
    int     left = 0;
    int     tgt = 0;
    bit     per = 0;
    int     periods = 0;
    bit     done_exp = 0;
    bit     prev_done = 0;
    int     done_log[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int log_at(int i);
        if (i < done_log.size()) return done_log[i];
        return -1;
    endfunction

    // one clock cycle: check outputs, advance the model, take the edge
    task automatic tick();
        bit run;
        bit match;
        #1;
        run   = (ph == P_RUN);
        match = run && (left == 0);
        chk("ready", cmd_ready_o, !reset_i && ph == P_IDLE);
        chk("busy", busy_o, !reset_i && ph != P_IDLE);
        chk("cnt_reset", cnt_reset_o,
            reset_i || ph == P_CLEAR || ph == P_FLUSH);
        chk("cnt_enable", cnt_enable_o,
            !reset_i && run && !pause_i && !match);
        chk("done", done_o, done_exp);
        chk("done_pulse", done_o && prev_done, 0);
        chk("periods", periods_o, periods);
        if (match) chk("count_at_match", cnt_count_i, tgt);
        if (done_o === 1'b1) done_log.push_back(cyc - acc_cyc);
        prev_done = (done_o === 1'b1);
        done_exp  = 0;
        if (reset_i) begin
            ph = P_IDLE; periods = 0; tgt = 0; per = 0;
        end else begin
            case (ph)
                P_IDLE: if (cmd_valid_i) begin
                    tgt     = cmd_target_i;
                    per     = cmd_periodic_i && cmd_target_i != 0;
                    periods = 0;
                    acc_cyc = cyc;
                    ph      = P_CLEAR;
                end
                P_CLEAR: begin
                    left = tgt * cpc;
                    ph   = abort_i ? P_FLUSH : P_RUN;
                end
                P_RUN: begin
                    if (abort_i) ph = P_FLUSH;
                    else if (match) begin
                        done_exp = 1;
                        if (periods < (1 << PW) - 1) periods++;
                        ph = per ? P_CLEAR : P_IDLE;
                    end else if (!pause_i) left--;
                end
                default: ph = P_IDLE;
            endcase
        end
        @(posedge clock_i);
        cyc++;
        #1;
    endtask

    task automatic cmd(int t, bit p);
        cmd_valid_i    = 1'b1;
        cmd_target_i   = 8'(t);
        cmd_periodic_i = p;
        done_log.delete();
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic stop();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        idle(2);
    endtask

    initial begin
        idle(2);
        reset_i = 1'b0;
        idle(2);

        // one-shot, C=4 T=3
        cpc = 4;
        cmd(3, 1'b0);
        idle(17);
        chk("os_ndone", done_log.size(), 1);
        chk("os_cycle", log_at(0), 15);
        chk("os_periods", periods_o, 1);

        // periodic, C=1 T=2, cycles 0..13
        cpc = 1;
        cmd(2, 1'b1);
        idle(13);
        chk("per_ndone", done_log.size(), 3);
        chk("per_d0", log_at(0), 5);
        chk("per_d1", log_at(1), 9);
        chk("per_d2", log_at(2), 13);
        stop();

        // pause cycles 3..7, C=1 T=4
        cmd(4, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            pause_i = (k >= 3 && k <= 7);
            tick();
        end
        pause_i = 1'b0;
        chk("pause_ndone", done_log.size(), 1);
        chk("pause_cycle", log_at(0), 12);

        // abort at cycle 6, C=2 T=10, new command at 8
        cpc = 2;
        cmd(10, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            abort_i = (k == 6);
            tick();
        end
        abort_i = 1'b0;
        chk("abort_ndone", done_log.size(), 0);
        chk("abort_periods", periods_o, 0);
        chk("abort_ready", cmd_ready_o, 1);
        cmd(1, 1'b0);
        idle(6);
        chk("post_abort_done", log_at(0), 5);

        // target 0 periodic: single done, then idle
        cmd(0, 1'b1);
        idle(5);
        chk("t0_ndone", done_log.size(), 1);
        chk("t0_cycle", log_at(0), 3);
        chk("t0_idle", busy_o, 0);

        // abort coincides with match, C=1 T=3 matches at 5
        cpc = 1;
        cmd(3, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            abort_i = (k == 5);
            tick();
        end
        abort_i = 1'b0;
        chk("coin_ndone", done_log.size(), 0);

        // saturation: 5 periods of T=1
        cmd(1, 1'b1);
        idle(17);
        chk("sat_ndone", done_log.size(), 5);
        chk("sat_periods", periods_o, 3);
        stop();

        // reset mid-RUN at cycle 5 of T=8
        cmd(8, 1'b0);
        idle(4);
        reset_i = 1'b1;
        #1;
        chk("rst_cnt_reset", cnt_reset_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_done", done_o, 0);
        idle(2);
        reset_i = 1'b0;
        tick();
        chk("rst_periods", periods_o, 0);
        chk("rst_ndone", done_log.size(), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (ph == P_IDLE && $urandom_range(0, 9) == 0)
                cpc = $urandom_range(1, 3);
            cmd_valid_i    = ($urandom_range(0, 9) < 3);
            cmd_target_i   = 8'($urandom_range(0, 12));
            cmd_periodic_i = $urandom_range(0, 1) == 1;
            pause_i        = ($urandom_range(0, 4) == 0);
            abort_i        = ($urandom_range(0, 39) == 0);
            reset_i        = !done_exp && ($urandom_range(0, 99) == 0);
            tick();
        end
        reset_i     = 1'b0;
        cmd_valid_i = 1'b0;
        abort_i     = 1'b0;
        pause_i     = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
